sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Initiator side of the 64-bit asynchronous-style SRAM interface (SRAM_DQ / SRAM_ADDR / SRAM_WE_N) that the SRAM model answers.
- Sits in the MEM stage of the ARM pipeline and turns 32-bit word load/store requests into multi-cycle 64-bit SRAM accesses.
- Stalls the pipeline through `ready` until each access completes.
- Stores are done as read-modify-write, because the SRAM has no byte or half enables.

Parameters:
- WAIT_CYCLES, 5, number of clk cycles each SRAM phase (read or write) holds address/data stable; must be >= 1.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- MEM_R_EN  input  1  load request, held by pipeline while ready=0
- MEM_W_EN  input  1  store request, held by pipeline while ready=0
- address  input  32  CPU byte address
- wdata  input  32  store data
- rdata  output  32  load data, valid when ready=1 in DONE
- ready  output  1  0 = freeze pipeline
- SRAM_DQ  inout  64  SRAM data bus
- SRAM_ADDR  output  17  SRAM 64-bit word address
- SRAM_WE_N  output  1  SRAM write enable, active low

Behaviour:
- Address map:
  - waddr = (address - BASE_ADDR) >> 2, 32-bit modulo arithmetic.
  - SRAM_ADDR = waddr[17:1].
  - half = waddr[0]; half 0 selects DQ[31:0], half 1 selects DQ[63:32].
  - Upper bits are truncated silently; there is no range check.
- Reset (async):
  - state = IDLE, counter = 0, SRAM_WE_N = 1, SRAM_ADDR = 0, rdata = 0, SRAM_DQ released (high-Z).
  - Reset mid-access aborts immediately. A half-done RMW leaves SRAM unchanged, because the write phase has not yet asserted WE_N.
- ready is combinational:
  - In IDLE: ready = !(MEM_R_EN | MEM_W_EN).
  - In DONE: ready = 1.
  - Otherwise: ready = 0.
- Request capture: address, wdata and the request type are latched on the IDLE->busy transition. Later input changes are ignored until the next IDLE.
- If MEM_R_EN and MEM_W_EN are both 1, the request is treated as a store.
- FSM states: IDLE, RD, WR_RD, WR, DONE.
- IDLE:
  - MEM_W_EN -> WR_RD.
  - Else MEM_R_EN -> RD.
  - Counter is cleared on exit.
- RD:
  - SRAM_ADDR driven, SRAM_WE_N = 1, DQ released.
  - After WAIT_CYCLES cycles, sample the selected 32-bit half of SRAM_DQ into rdata, then -> DONE.
- WR_RD:
  - Same as RD, but sample the full 64-bit line into a merge register.
  - The captured wdata replaces the selected half.
  - -> WR.
- WR:
  - SRAM_WE_N = 0; SRAM_DQ driven with the merged line for exactly WAIT_CYCLES cycles.
  - On the last cycle SRAM_WE_N returns to 1 at the transition to DONE.
  - DQ is released in the same cycle WE_N deasserts.
- DONE:
  - Exactly one cycle, ready = 1; the pipeline advances on this edge.
  - -> IDLE.
  - A new request seen in the following IDLE cycle starts a new access; there is no back-to-back shortcut.
- Latency, measured as cycles with ready = 0 starting at the request cycle:
  - Load: 1 + WAIT_CYCLES.
  - Store: 1 + 2*WAIT_CYCLES.
  - In both cases ready = 1 on the following cycle (DONE).
- SRAM_DQ is never driven by this block while SRAM_WE_N = 1 (no bus contention).
- rdata holds its last value outside DONE and is not updated by stores.

Decomposition:
- Shared package/header: FSM state encodings, BASE_ADDR default, SRAM widths (64 data, 17 address).
- No sub-module is needed, except an optional sram_wait_counter: a parameterised down-counter with a `done` flag, reusable by the cache controller.

Test Plan:
- Reset:
  - Stimulus: hold rst = 1 mid-RD, then release.
  - Required: SRAM_WE_N = 1, DQ = z and ready = 1 with no request; the next load restarts from IDLE.
- Load, low half:
  - Stimulus: SRAM line 0 preloaded with 64'hAAAA_BBBB_1111_2222; load address 1024, WAIT_CYCLES = 5.
  - Required: ready = 0 for 6 cycles, then rdata = 32'h1111_2222 with ready = 1 for exactly one cycle.
- Load, high half:
  - Stimulus: same line, load address 1028.
  - Required: rdata = 32'hAAAA_BBBB; SRAM_ADDR = 0.
- Store RMW:
  - Stimulus: store 32'hDEAD_BEEF to address 1036 with line 1 = 64'h0123_4567_89AB_CDEF.
  - Required:
    - SRAM_ADDR = 1.
    - WE_N low for 5 cycles with DQ = 64'hDEAD_BEEF_89AB_CDEF.
    - Total ready = 0 count is 11.
    - A subsequent load of 1032 returns 32'h89AB_CDEF.
- Simultaneous enables:
  - Stimulus: MEM_R_EN = MEM_W_EN = 1 at address 1024 with wdata = 5.
  - Required: the store path is taken; a subsequent load returns 5.
- Back-to-back:
  - Stimulus: store followed immediately by a load to the same address.
  - Required: the load returns the stored value; IDLE is observed for one cycle between the accesses; DQ is never driven while WE_N = 1 (checked every cycle).

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller and its helpers.
// Includes the FSM state encoding, bus widths, and the CPU-address-to-SRAM-word mapping.
package sram_controller_pkg;

  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_ADDR_W = 17;
  localparam int CPU_DATA_W  = 32;

  localparam int          DEFAULT_WAIT_CYCLES = 5;
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_RD,
    ST_WR,
    ST_DONE
  } state_t;

  // 32-bit word index relative to the SRAM base.
  // Bit 0 picks the half of the 64-bit line; bits 17:1 are the line address.
  function automatic logic [17:0] word_index(input logic [31:0] address,
                                             input logic [31:0] base);
    return 18'((address - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side load/store handshake between the MEM stage and the SRAM controller.
interface sram_controller_if;

  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output MEM_R_EN, MEM_W_EN, address, wdata,
    input  rdata, ready
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Reloadable down-counter that times one SRAM phase.
// The done flag is high on the final cycle of the phase.
module sram_wait_counter #(
  parameter int CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= W'(CYCLES - 1);
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/sram_controller.sv
// Turns 32-bit word loads/stores into timed 64-bit SRAM accesses.
// Stores are implemented as a read-modify-write of the containing line.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       mem,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N
);

  state_t state_reg, state_next;

  logic [SRAM_ADDR_W-1:0] sram_addr_reg;
  logic                   half_reg;
  logic [CPU_DATA_W-1:0]  wdata_reg;
  logic [CPU_DATA_W-1:0]  rdata_reg;
  logic [SRAM_DATA_W-1:0] line_reg;
  logic                   we_n_reg;

  logic [17:0] waddr;
  logic        cnt_load;
  logic        cnt_en;
  logic        cnt_done;
  logic        ready;

  assign waddr = word_index(mem.address, BASE_ADDR);

  sram_wait_counter #(
    .CYCLES (WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .done (cnt_done)
  );

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready = !(mem.MEM_R_EN | mem.MEM_W_EN);
        if (mem.MEM_W_EN) begin
          state_next = ST_WR_RD;
          cnt_load   = 1'b1;
        end else if (mem.MEM_R_EN) begin
          state_next = ST_RD;
          cnt_load   = 1'b1;
        end
      end
      ST_RD: begin
        cnt_en = 1'b1;
        if (cnt_done) state_next = ST_DONE;
      end
      ST_WR_RD: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          state_next = ST_WR;
          cnt_load   = 1'b1;
        end
      end
      ST_WR: begin
        cnt_en = 1'b1;
        if (cnt_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        ready      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      we_n_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      // WE_N tracks the WR state exactly, so it rises on the WR->DONE edge.
      we_n_reg  <= (state_next != ST_WR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr_reg <= '0;
      half_reg      <= 1'b0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      line_reg      <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && (state_next != ST_IDLE)) begin
        sram_addr_reg <= waddr[17:1];
        half_reg      <= waddr[0];
        wdata_reg     <= mem.wdata;
      end
      if ((state_reg == ST_RD) && cnt_done) begin
        rdata_reg <= half_reg ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
      end
      if ((state_reg == ST_WR_RD) && cnt_done) begin
        line_reg <= half_reg ? {wdata_reg, SRAM_DQ[31:0]}
                             : {SRAM_DQ[63:32], wdata_reg};
      end
    end
  end

  // The bus is only driven while WE_N is low, so there is never contention.
  assign SRAM_DQ   = we_n_reg ? {SRAM_DATA_W{1'bz}} : line_reg;
  assign SRAM_ADDR = sram_addr_reg;
  assign SRAM_WE_N = we_n_reg;
  assign mem.rdata = rdata_reg;
  assign mem.ready = ready;

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a behavioural SRAM model.
// Checks latency, data, addressing, write-phase bus contents and reset behaviour.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  wire  [63:0] sram_dq;
  logic [16:0] sram_addr;
  logic        sram_we_n;

  sram_controller_if bus ();

  sram_controller #(
    .WAIT_CYCLES (5),
    .BASE_ADDR   (32'd1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n)
  );

  // SRAM model: drives the bus whenever WE_N is high, writes on clock while low.
  logic [63:0] sram_mem [0:(1<<17)-1];
  assign sram_dq = sram_we_n ? sram_mem[sram_addr] : {64{1'bz}};

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          we_low_cnt   = 0;
  logic [63:0] exp_wline    = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every cycle: no contention while WE_N is high, merged line while WE_N is low.
  always @(negedge clk) begin
    if (sram_we_n) begin
      check("dq_released", sram_dq, sram_mem[sram_addr]);
    end else begin
      we_low_cnt++;
      check("dq_write_line", sram_dq, exp_wline);
    end
  end

  // Issues a request (caller is just after a rising edge), counts ready=0 cycles,
  // captures rdata/SRAM_ADDR in DONE, and returns just after the DONE edge.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] got,
                            output logic [16:0] line, output int lat);
    bit seen_ready;
    bus.MEM_R_EN = rd;
    bus.MEM_W_EN = wr;
    bus.address  = addr;
    bus.wdata    = wd;
    we_low_cnt   = 0;
    lat          = 0;
    seen_ready   = 1'b0;
    got          = '0;
    line         = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        got        = bus.rdata;
        line       = sram_addr;
        seen_ready = 1'b1;
        break;
      end
      lat++;
    end
    if (!seen_ready) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    $display("[TB] access rd=%0b wr=%0b addr=%0d wdata=%h -> rdata=%h line=%0d lat=%0d we_low=%0d",
             rd, wr, addr, wd, got, line, lat, we_low_cnt);
  endtask

  task automatic idle_inputs();
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we_n"}, 64'(sram_we_n), 64'd1);
    check({tag, "_addr"}, 64'(sram_addr), 64'd0);
    check({tag, "_rdata"}, 64'(bus.rdata), 64'd0);
    check({tag, "_ready"}, 64'(bus.ready), 64'd1);
  endtask

  logic [31:0] got;
  logic [16:0] line;
  int          lat;

  initial begin
    sram_mem[0] = 64'hAAAA_BBBB_1111_2222;
    sram_mem[1] = 64'h0123_4567_89AB_CDEF;
    rst = 1'b1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.address  = '0;
    bus.wdata    = '0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load low half, then high half back-to-back (proves DONE lasts one cycle)
    run_access(1'b1, 1'b0, 32'd1024, 32'd0, got, line, lat);
    check("ld_lo_lat", 64'(lat), 64'd6);
    check("ld_lo_data", 64'(got), 64'h1111_2222);
    check("ld_lo_line", 64'(line), 64'd0);
    run_access(1'b1, 1'b0, 32'd1028, 32'd0, got, line, lat);
    check("ld_hi_lat", 64'(lat), 64'd6);
    check("ld_hi_data", 64'(got), 64'hAAAA_BBBB);
    check("ld_hi_line", 64'(line), 64'd0);
    idle_inputs();
    @(negedge clk);
    check("idle_ready", 64'(bus.ready), 64'd1);
    @(posedge clk);
    #1;

    // Store RMW into the high half of line 1
    exp_wline = 64'hDEAD_BEEF_89AB_CDEF;
    run_access(1'b0, 1'b1, 32'd1036, 32'hDEAD_BEEF, got, line, lat);
    check("st_lat", 64'(lat), 64'd11);
    check("st_line", 64'(line), 64'd1);
    check("st_we_low", 64'(we_low_cnt), 64'd5);
    idle_inputs();
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'd1032, 32'd0, got, line, lat);
    check("st_ld_lo_data", 64'(got), 64'h89AB_CDEF);
    check("st_ld_lo_we_low", 64'(we_low_cnt), 64'd0);
    run_access(1'b1, 1'b0, 32'd1036, 32'd0, got, line, lat);
    check("st_ld_hi_data", 64'(got), 64'hDEAD_BEEF);
    idle_inputs();
    @(posedge clk);
    #1;

    // Both enables: store wins
    exp_wline = 64'hAAAA_BBBB_0000_0005;
    run_access(1'b1, 1'b1, 32'd1024, 32'd5, got, line, lat);
    check("both_lat", 64'(lat), 64'd11);
    check("both_we_low", 64'(we_low_cnt), 64'd5);
    idle_inputs();
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'd1024, 32'd0, got, line, lat);
    check("both_ld_data", 64'(got), 64'd5);
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset during the read phase of an RMW: SRAM must be untouched
    bus.MEM_W_EN = 1'b1;
    bus.address  = 32'd1024;
    bus.wdata    = 32'hFFFF_0000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check_reset_state("rst_rmw");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'd1024, 32'd0, got, line, lat);
    check("rst_rmw_lat", 64'(lat), 64'd6);
    check("rst_rmw_lo", 64'(got), 64'd5);
    run_access(1'b1, 1'b0, 32'd1028, 32'd0, got, line, lat);
    check("rst_rmw_hi", 64'(got), 64'hAAAA_BBBB);
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset mid-RD, then the next load restarts from IDLE
    bus.MEM_R_EN = 1'b1;
    bus.address  = 32'd1032;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check_reset_state("rst_rd");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'd1032, 32'd0, got, line, lat);
    check("rst_rd_lat", 64'(lat), 64'd6);
    check("rst_rd_data", 64'(got), 64'h89AB_CDEF);
    check("rst_rd_line", 64'(line), 64'd1);
    idle_inputs();
    @(posedge clk);
    #1;

    // Store immediately followed by a load of the same word
    exp_wline = 64'h1234_5678_0000_0005;
    run_access(1'b0, 1'b1, 32'd1028, 32'h1234_5678, got, line, lat);
    check("b2b_st_lat", 64'(lat), 64'd11);
    check("b2b_st_we_low", 64'(we_low_cnt), 64'd5);
    run_access(1'b1, 1'b0, 32'd1028, 32'd0, got, line, lat);
    check("b2b_ld_lat", 64'(lat), 64'd6);
    check("b2b_ld_data", 64'(got), 64'h1234_5678);
    check("b2b_ld_line", 64'(line), 64'd0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
